// File: rtl/ibex_mem_port_arbiter.sv
// Merges the Ibex instruction and data MEM ports onto one shared MEM port.
// Arbitration is round-robin, and an in-order ID FIFO routes each response back to its requester.
module ibex_mem_port_arbiter #(
   parameter int unsigned LOCAL_DATA_WIDTH = 32,
   parameter int unsigned LOCAL_ADDR_WIDTH = 32,
   parameter int unsigned MAX_OUTSTANDING  = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          instr_mem_req,
   output logic                          instr_mem_gnt,
   output logic                          instr_mem_valid,
   input  logic [LOCAL_ADDR_WIDTH-1:0]   instr_mem_addr,
   output logic [LOCAL_DATA_WIDTH-1:0]   instr_mem_rdata,
   input  logic [LOCAL_DATA_WIDTH-1:0]   instr_mem_wdata,
   input  logic                          instr_mem_we,
   input  logic [LOCAL_DATA_WIDTH/8-1:0] instr_mem_be,
   input  logic                          data_mem_req,
   output logic                          data_mem_gnt,
   output logic                          data_mem_valid,
   input  logic [LOCAL_ADDR_WIDTH-1:0]   data_mem_addr,
   output logic [LOCAL_DATA_WIDTH-1:0]   data_mem_rdata,
   input  logic [LOCAL_DATA_WIDTH-1:0]   data_mem_wdata,
   input  logic                          data_mem_we,
   input  logic [LOCAL_DATA_WIDTH/8-1:0] data_mem_be,
   output logic                          out_mem_req,
   input  logic                          out_mem_gnt,
   input  logic                          out_mem_valid,
   output logic [LOCAL_ADDR_WIDTH-1:0]   out_mem_addr,
   input  logic [LOCAL_DATA_WIDTH-1:0]   out_mem_rdata,
   output logic [LOCAL_DATA_WIDTH-1:0]   out_mem_wdata,
   output logic                          out_mem_we,
   output logic [LOCAL_DATA_WIDTH/8-1:0] out_mem_be,
   output logic                          protocol_err_o
);

   localparam int unsigned BE_W  = LOCAL_DATA_WIDTH / 8;
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam logic       SRC_INSTR = 1'b0;
   localparam logic       SRC_DATA  = 1'b1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
   endfunction

   logic [0:0]       state_r;
   logic             locked_sel_r;
   logic             last_grant_r;
   logic             id_fifo_r [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             err_r;

   logic sel_s;
   logic want_s;
   logic full_s;
   logic empty_s;
   logic accept_s;
   logic pop_s;
   logic head_s;

   // Instruction fetches are read-only, so their write-side inputs are intentionally unused.
   logic unused_instr_wr_s;
   assign unused_instr_wr_s = ^{instr_mem_wdata, instr_mem_we, instr_mem_be};

   assign full_s   = (count_r == CNT_FULL);
   assign empty_s  = (count_r == {CNT_W{1'b0}});
   assign accept_s = out_mem_req & out_mem_gnt;
   assign pop_s    = out_mem_valid & ~empty_s;
   assign head_s   = id_fifo_r[rd_ptr_r];

   // Source selection: a locked selection is held; otherwise round-robin against last_grant.
   always_comb begin
      sel_s  = SRC_INSTR;
      want_s = 1'b0;
      if (state_r == ST_LOCKED) begin
         sel_s  = locked_sel_r;
         want_s = 1'b1;
      end else if (instr_mem_req && data_mem_req) begin
         sel_s  = ~last_grant_r;
         want_s = 1'b1;
      end else if (data_mem_req) begin
         sel_s  = SRC_DATA;
         want_s = 1'b1;
      end else begin
         sel_s  = SRC_INSTR;
         want_s = instr_mem_req;
      end
   end

   // Shared request mux with zero added latency; a full FIFO blocks the request.
   always_comb begin
      out_mem_req   = 1'b0;
      out_mem_addr  = {LOCAL_ADDR_WIDTH{1'b0}};
      out_mem_wdata = {LOCAL_DATA_WIDTH{1'b0}};
      out_mem_we    = 1'b0;
      out_mem_be    = {BE_W{1'b0}};
      instr_mem_gnt = 1'b0;
      data_mem_gnt  = 1'b0;
      if (want_s && !full_s) begin
         out_mem_req = 1'b1;
         if (sel_s == SRC_DATA) begin
            out_mem_addr  = data_mem_addr;
            out_mem_wdata = data_mem_wdata;
            out_mem_we    = data_mem_we;
            out_mem_be    = data_mem_be;
            data_mem_gnt  = out_mem_gnt;
         end else begin
            out_mem_addr  = instr_mem_addr;
            out_mem_be    = {BE_W{1'b1}};
            instr_mem_gnt = out_mem_gnt;
         end
      end else begin
         out_mem_req = 1'b0;
      end
   end

   // Response routing by FIFO head; rdata is broadcast while a response is on the bus.
   always_comb begin
      instr_mem_valid = 1'b0;
      data_mem_valid  = 1'b0;
      instr_mem_rdata = {LOCAL_DATA_WIDTH{1'b0}};
      data_mem_rdata  = {LOCAL_DATA_WIDTH{1'b0}};
      if (pop_s) begin
         instr_mem_valid = (head_s == SRC_INSTR);
         data_mem_valid  = (head_s == SRC_DATA);
      end else begin
         instr_mem_valid = 1'b0;
         data_mem_valid  = 1'b0;
      end
      if (out_mem_valid) begin
         instr_mem_rdata = out_mem_rdata;
         data_mem_rdata  = out_mem_rdata;
      end else begin
         instr_mem_rdata = {LOCAL_DATA_WIDTH{1'b0}};
         data_mem_rdata  = {LOCAL_DATA_WIDTH{1'b0}};
      end
   end

   // Handshake FSM and round-robin history.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_IDLE;
         locked_sel_r <= SRC_INSTR;
         last_grant_r <= SRC_INSTR;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (out_mem_req && !out_mem_gnt) begin
                  state_r      <= ST_LOCKED;
                  locked_sel_r <= sel_s;
               end
            end
            ST_LOCKED: begin
               if (accept_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
         if (accept_s) begin
            last_grant_r <= sel_s;
         end
      end
   end

   // In-order ID FIFO; push on accept, pop on a tracked response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            id_fifo_r[i] <= SRC_INSTR;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (accept_s) begin
            id_fifo_r[wr_ptr_r] <= sel_s;
            wr_ptr_r            <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({accept_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky flag for responses that arrive with nothing outstanding.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_r <= 1'b0;
      end else if (out_mem_valid && empty_s) begin
         err_r <= 1'b1;
      end
   end

   assign protocol_err_o = err_r;

endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Directed self-checking bench for ibex_mem_port_arbiter (MAX_OUTSTANDING = 2).
// Inputs change on the falling edge and outputs are sampled 1ns later.
module tb_ibex_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        instr_req, instr_gnt, instr_valid, instr_we;
   logic [31:0] instr_addr, instr_rdata, instr_wdata;
   logic [3:0]  instr_be;
   logic        data_req, data_gnt, data_valid, data_we;
   logic [31:0] data_addr, data_rdata, data_wdata;
   logic [3:0]  data_be;
   logic        out_req, out_gnt, out_valid, out_we;
   logic [31:0] out_addr, out_rdata, out_wdata;
   logic [3:0]  out_be;
   logic        prot_err;

   int checks = 0;
   int errors = 0;
   int d_grants;
   int i_grants;

   ibex_mem_port_arbiter #(
      .LOCAL_DATA_WIDTH(32),
      .LOCAL_ADDR_WIDTH(32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .instr_mem_req  (instr_req),
      .instr_mem_gnt  (instr_gnt),
      .instr_mem_valid(instr_valid),
      .instr_mem_addr (instr_addr),
      .instr_mem_rdata(instr_rdata),
      .instr_mem_wdata(instr_wdata),
      .instr_mem_we   (instr_we),
      .instr_mem_be   (instr_be),
      .data_mem_req   (data_req),
      .data_mem_gnt   (data_gnt),
      .data_mem_valid (data_valid),
      .data_mem_addr  (data_addr),
      .data_mem_rdata (data_rdata),
      .data_mem_wdata (data_wdata),
      .data_mem_we    (data_we),
      .data_mem_be    (data_be),
      .out_mem_req    (out_req),
      .out_mem_gnt    (out_gnt),
      .out_mem_valid  (out_valid),
      .out_mem_addr   (out_addr),
      .out_mem_rdata  (out_rdata),
      .out_mem_wdata  (out_wdata),
      .out_mem_we     (out_we),
      .out_mem_be     (out_be),
      .protocol_err_o (prot_err)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      instr_req = 1'b0; instr_addr = 32'h0; instr_wdata = 32'h0; instr_we = 1'b0; instr_be = 4'h0;
      data_req  = 1'b0; data_addr  = 32'h0; data_wdata  = 32'h0; data_we  = 1'b0; data_be  = 4'h0;
      out_gnt   = 1'b0; out_valid  = 1'b0; out_rdata   = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check_value("rst_out_req", {63'd0, out_req}, 64'd0);
      check_value("rst_out_addr", {32'd0, out_addr}, 64'd0);
      check_value("rst_gnts", {62'd0, instr_gnt, data_gnt}, 64'd0);
      check_value("rst_valids", {62'd0, instr_valid, data_valid}, 64'd0);
      check_value("rst_err", {63'd0, prot_err}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1. single instruction fetch
      @(negedge clk);
      instr_req = 1'b1; instr_addr = 32'h100; instr_we = 1'b1; instr_be = 4'h2; out_gnt = 1'b1;
      #1;
      check_value("t1_out_req", {63'd0, out_req}, 64'd1);
      check_value("t1_out_addr", {32'd0, out_addr}, 64'h100);
      check_value("t1_instr_gnt", {63'd0, instr_gnt}, 64'd1);
      check_value("t1_data_gnt", {63'd0, data_gnt}, 64'd0);
      check_value("t1_out_we", {63'd0, out_we}, 64'd0);
      check_value("t1_out_be", {60'd0, out_be}, 64'hF);
      @(negedge clk);
      idle_inputs();
      #1;
      check_value("t1_idle_req", {63'd0, out_req}, 64'd0);
      @(negedge clk);
      out_valid = 1'b1; out_rdata = 32'hDEADBEEF;
      #1;
      check_value("t1_instr_valid", {63'd0, instr_valid}, 64'd1);
      check_value("t1_instr_rdata", {32'd0, instr_rdata}, 64'hDEADBEEF);
      check_value("t1_data_valid", {63'd0, data_valid}, 64'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check_value("t1_valid_clr", {62'd0, instr_valid, data_valid}, 64'd0);
      check_value("t1_err", {63'd0, prot_err}, 64'd0);

      // 2. conflict right after reset: data wins first
      do_reset();
      @(negedge clk);
      instr_req = 1'b1; instr_addr = 32'h200;
      data_req = 1'b1; data_addr = 32'h8000; data_we = 1'b1; data_be = 4'hF; data_wdata = 32'h12345678;
      out_gnt = 1'b1;
      #1;
      check_value("t2_first_addr", {32'd0, out_addr}, 64'h8000);
      check_value("t2_first_gnts", {62'd0, instr_gnt, data_gnt}, 64'b01);
      check_value("t2_first_we", {63'd0, out_we}, 64'd1);
      check_value("t2_first_wdata", {32'd0, out_wdata}, 64'h12345678);
      @(negedge clk);
      data_req = 1'b0;
      #1;
      check_value("t2_second_addr", {32'd0, out_addr}, 64'h200);
      check_value("t2_second_gnts", {62'd0, instr_gnt, data_gnt}, 64'b10);
      check_value("t2_second_we", {63'd0, out_we}, 64'd0);
      check_value("t2_second_wdata", {32'd0, out_wdata}, 64'd0);
      @(negedge clk);
      idle_inputs();
      out_valid = 1'b1; out_rdata = 32'hAAAA0001;
      #1;
      check_value("t2_resp1_valids", {62'd0, instr_valid, data_valid}, 64'b01);
      check_value("t2_resp1_rdata", {32'd0, data_rdata}, 64'hAAAA0001);
      @(negedge clk);
      out_rdata = 32'hBBBB0002;
      #1;
      check_value("t2_resp2_valids", {62'd0, instr_valid, data_valid}, 64'b10);
      check_value("t2_resp2_rdata", {32'd0, instr_rdata}, 64'hBBBB0002);

      // 3. sustained conflict: 8 grants alternate D,I,...; each response pops the previous grant
      d_grants = 0;
      i_grants = 0;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         instr_req = (k < 8); instr_addr = 32'h1000 + 32'(k);
         data_req  = (k < 8); data_addr  = 32'h2000 + 32'(k);
         out_gnt   = (k < 8);
         out_valid = (k > 0); out_rdata = 32'h5000 + 32'(k);
         #1;
         if (k < 8) begin
            check_value($sformatf("t3_gnts_%0d", k), {62'd0, instr_gnt, data_gnt},
                        (k % 2 == 0) ? 64'b01 : 64'b10);
            d_grants += int'(data_gnt);
            i_grants += int'(instr_gnt);
         end
         if (k > 0) begin
            check_value($sformatf("t3_valids_%0d", k), {62'd0, instr_valid, data_valid},
                        ((k - 1) % 2 == 0) ? 64'b01 : 64'b10);
         end
      end
      check_value("t3_data_grants", 64'(d_grants), 64'd4);
      check_value("t3_instr_grants", 64'(i_grants), 64'd4);

      // 4. backpressure lock on data while instr requests (data drops req mid-lock)
      @(negedge clk);
      idle_inputs();
      instr_req = 1'b1; instr_addr = 32'h300;
      data_req = 1'b1; data_addr = 32'h4000; data_we = 1'b1; data_be = 4'h3;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 2) data_req = 1'b0;
         #1;
         check_value($sformatf("t4_lock_addr_%0d", c), {32'd0, out_addr}, 64'h4000);
         check_value($sformatf("t4_lock_gnts_%0d", c), {62'd0, instr_gnt, data_gnt}, 64'b00);
      end
      @(negedge clk);
      out_gnt = 1'b1;
      #1;
      check_value("t4_release_addr", {32'd0, out_addr}, 64'h4000);
      check_value("t4_release_gnts", {62'd0, instr_gnt, data_gnt}, 64'b01);
      check_value("t4_release_be", {60'd0, out_be}, 64'h3);
      @(negedge clk);
      #1;
      check_value("t4_instr_addr", {32'd0, out_addr}, 64'h300);
      check_value("t4_instr_gnts", {62'd0, instr_gnt, data_gnt}, 64'b10);

      // 5. FIFO full: no request until the cycle after a response
      @(negedge clk);
      #1;
      check_value("t5_full_req", {63'd0, out_req}, 64'd0);
      check_value("t5_full_gnt", {63'd0, instr_gnt}, 64'd0);
      @(negedge clk);
      out_valid = 1'b1; out_rdata = 32'h0C0FFEE0;
      #1;
      check_value("t5_pop_data_valid", {63'd0, data_valid}, 64'd1);
      check_value("t5_pop_cycle_req", {63'd0, out_req}, 64'd0);
      check_value("t5_pop_cycle_gnt", {63'd0, instr_gnt}, 64'd0);
      @(negedge clk);
      out_valid = 1'b0;
      #1;
      check_value("t5_next_req", {63'd0, out_req}, 64'd1);
      check_value("t5_next_gnt", {63'd0, instr_gnt}, 64'd1);
      @(negedge clk);
      idle_inputs();
      out_valid = 1'b1;
      #1;
      check_value("t5_drain1", {62'd0, instr_valid, data_valid}, 64'b10);
      @(negedge clk);
      #1;
      check_value("t5_drain2", {62'd0, instr_valid, data_valid}, 64'b10);
      check_value("t5_err_before", {63'd0, prot_err}, 64'd0);

      // 6. spurious response with empty FIFO
      @(negedge clk);
      #1;
      check_value("t6_spur_valids", {62'd0, instr_valid, data_valid}, 64'b00);
      @(negedge clk);
      out_valid = 1'b0;
      #1;
      check_value("t6_err_set", {63'd0, prot_err}, 64'd1);
      repeat (2) @(negedge clk);
      #1;
      check_value("t6_err_sticky", {63'd0, prot_err}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_value("t6_err_reset", {63'd0, prot_err}, 64'd0);
      check_value("t6_out_req_reset", {63'd0, out_req}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
